axis_to_bram_writer: RTL and testbench
======================================

Name: axis_to_bram_writer

Overview:
Upstream feeder for data_mover_bram. It accepts an AXI4-Stream burst and writes each beat into BRAM0 through one true_dpbram port. Writes go to consecutive addresses starting at 0. The block signals done once the programmed number of beats has landed, so the controller can then start data_mover_bram.

Parameters:
CNT_BIT, 31, width of the beat counter and of i_num_cnt.
DWIDTH, 32, stream data width and BRAM data width.
AWIDTH, 12, BRAM address width.
MEM_SIZE, 4096, BRAM depth in words; the maximum legal i_num_cnt.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_run  in  1  one-cycle start pulse, sampled only in S_IDLE
i_num_cnt  in  CNT_BIT  number of beats to write, latched on start
o_idle  out  1  high in S_IDLE
o_run  out  1  high in S_RUN
o_done  out  1  one-cycle pulse in S_DONE
o_err_early  out  1  sticky: tlast was accepted before the count was reached; cleared on next start
o_err_nolast  out  1  sticky: count was reached without tlast on the final beat; cleared on next start
o_wr_cnt  out  CNT_BIT  beats written in the current or last transfer
s_axis_tdata  in  DWIDTH  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  stream last
addr_b0  out  AWIDTH  BRAM write address
ce_b0  out  1  BRAM chip enable
we_b0  out  1  BRAM write enable
d_b0  out  DWIDTH  BRAM write data

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on posedge clk. While reset is high, the following hold:
  - state = S_IDLE, o_idle = 1;
  - o_run, o_done, o_err_early, o_err_nolast, s_axis_tready, ce_b0, we_b0 = 0;
  - o_wr_cnt, addr_b0, d_b0 = 0.
- Reset mid-transfer aborts immediately. No further BRAM writes occur; data already written stays in BRAM.
- FSM has 3 states, S_IDLE -> S_RUN -> S_DONE -> S_IDLE.
- S_IDLE:
  - s_axis_tready = 0.
  - On i_run = 1, latch i_num_cnt into num_cnt_r, clear o_wr_cnt and both error flags, and set the address counter to 0.
  - Go to S_RUN, or go straight to S_DONE if i_num_cnt == 0.
  - i_run outside S_IDLE is ignored.
- S_RUN:
  - s_axis_tready = 1 (combinational from state).
  - A handshake is tvalid && tready in the same cycle.
  - On each handshake, the next cycle presents one registered write: ce_b0 = we_b0 = 1, addr_b0 = address counter, d_b0 = tdata. Then the address counter and o_wr_cnt increment.
  - Latency from handshake to BRAM write strobe is exactly 1 cycle. Back-to-back beats give back-to-back writes at full throughput.
  - ce_b0/we_b0 drop to 0 in the cycle after a cycle with no handshake.
- Termination from S_RUN:
  - Count reached with tlast = 1 on the last beat: clean end.
  - Count reached with tlast = 0 on the last beat: set o_err_nolast.
  - tlast = 1 on an earlier beat: set o_err_early.
  - In all three cases, tready deasserts in the next cycle, the final beat is still written, and the FSM goes to S_DONE.
  - Beats beyond the count are not accepted. They stay in the stream and are left for the next start.
- Address:
  - addr_b0 = o_wr_cnt[AWIDTH-1:0].
  - i_num_cnt > MEM_SIZE is illegal. The address wraps modulo 2^AWIDTH and no protection is provided.
- S_DONE: lasts exactly 1 cycle, with o_done = 1 and no BRAM write. Next state is S_IDLE.
- o_wr_cnt and the error flags hold their values after the transfer until the next accepted i_run or reset.
- In S_IDLE, i_run and tvalid may both be high in the same cycle. The beat is not accepted that cycle; it is accepted on the first S_RUN cycle at the earliest.

Test Plan:
1. Reset, then i_num_cnt = 3840, continuous tvalid, tdata = i, tlast on beat 3839 -> BRAM0[i] = i for i = 0..3839; o_done pulses once; o_wr_cnt = 3840; both error flags 0.
2. Same transfer with tvalid randomly gated at 50% -> identical BRAM contents; we_b0 count = 3840; no write is duplicated.
3. i_num_cnt = 16, tlast on beat 9 -> 10 writes (addr 0..9); o_err_early = 1; o_wr_cnt = 10; o_done pulses.
4. i_num_cnt = 8, no tlast, 12 beats offered -> 8 writes; o_err_nolast = 1; beats 8..11 not accepted (tready = 0 after the 8th handshake).
5. i_num_cnt = 0 -> S_DONE on the cycle after i_run; no BRAM write; o_wr_cnt = 0.
6. Reset asserted after 100 beats of a 3840-beat transfer -> the following cycle o_idle = 1, tready = 0, we_b0 = 0; BRAM0[0..99] retained; a new run then completes normally.

Source files
------------

// File: rtl/axis_to_bram_writer.sv
// AXI4-Stream to BRAM writer: stores a programmed-length burst at consecutive
// addresses from 0 and pulses o_done when the last beat has been written.
module axis_to_bram_writer #(
   parameter int unsigned CNT_BIT  = 31,
   parameter int unsigned DWIDTH   = 32,
   parameter int unsigned AWIDTH   = 12,
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   output logic               o_idle,
   output logic               o_run,
   output logic               o_done,
   output logic               o_err_early,
   output logic               o_err_nolast,
   output logic [CNT_BIT-1:0] o_wr_cnt,
   input  logic [DWIDTH-1:0]  s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tlast,
   output logic [AWIDTH-1:0]  addr_b0,
   output logic               ce_b0,
   output logic               we_b0,
   output logic [DWIDTH-1:0]  d_b0
);

   // The BRAM must fit in the address space; larger counts simply wrap.
   if (64'(MEM_SIZE) > (64'd1 << AWIDTH)) begin : g_bad_mem_size
      $error("MEM_SIZE exceeds the BRAM address space");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_BIT-1:0]  num_cnt_q, num_cnt_d;
   logic [CNT_BIT-1:0]  wr_cnt_q, wr_cnt_d;
   logic                err_early_q, err_early_d;
   logic                err_nolast_q, err_nolast_d;
   logic                we_q, we_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic [DWIDTH-1:0]   data_q, data_d;
   logic                idle_q, idle_d;
   logic                run_q, run_d;
   logic                done_q, done_d;

   logic                hs_c;
   logic                last_beat_c;
   logic [CNT_BIT-1:0]  wr_cnt_inc_c;

   assign s_axis_tready = (state_q == S_RUN);
   assign hs_c          = s_axis_tvalid && s_axis_tready;
   assign wr_cnt_inc_c  = wr_cnt_q + CNT_BIT'(1);
   assign last_beat_c   = (wr_cnt_inc_c == num_cnt_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      num_cnt_d    = num_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      err_early_d  = err_early_q;
      err_nolast_d = err_nolast_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;

      case (state_q)
         S_IDLE: begin
            if (i_run) begin
               num_cnt_d    = i_num_cnt;
               wr_cnt_d     = '0;
               err_early_d  = 1'b0;
               err_nolast_d = 1'b0;
               state_d      = (i_num_cnt == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (hs_c) begin
               we_d     = 1'b1;
               addr_d   = wr_cnt_q[AWIDTH-1:0];
               data_d   = s_axis_tdata;
               wr_cnt_d = wr_cnt_inc_c;
               if (last_beat_c || s_axis_tlast) begin
                  state_d = S_DONE;
               end
               if (last_beat_c && !s_axis_tlast) begin
                  err_nolast_d = 1'b1;
               end
               if (s_axis_tlast && !last_beat_c) begin
                  err_early_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      idle_d = (state_d == S_IDLE);
      run_d  = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         num_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         err_early_q  <= 1'b0;
         err_nolast_q <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         idle_q       <= 1'b1;
         run_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_cnt_q    <= num_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         err_early_q  <= err_early_d;
         err_nolast_q <= err_nolast_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         idle_q       <= idle_d;
         run_q        <= run_d;
         done_q       <= done_d;
      end
   end

   assign o_idle       = idle_q;
   assign o_run        = run_q;
   assign o_done       = done_q;
   assign o_err_early  = err_early_q;
   assign o_err_nolast = err_nolast_q;
   assign o_wr_cnt     = wr_cnt_q;
   assign ce_b0        = we_q;
   assign we_b0        = we_q;
   assign addr_b0      = addr_q;
   assign d_b0         = data_q;

endmodule

// File: tb/tb_axis_to_bram_writer.sv
// Scoreboard bench for axis_to_bram_writer: directed bursts with expected
// BRAM writes queued up front and checked by an independent write monitor.
module tb_axis_to_bram_writer;

   localparam int unsigned CNT_BIT  = 31;
   localparam int unsigned DWIDTH   = 32;
   localparam int unsigned AWIDTH   = 12;
   localparam int unsigned MEM_SIZE = 4096;

   typedef struct {
      logic [AWIDTH-1:0] addr;
      logic [DWIDTH-1:0] data;
   } wr_t;

   logic               clk;
   logic               reset;
   logic               i_run;
   logic [CNT_BIT-1:0] i_num_cnt;
   logic               o_idle, o_run, o_done, o_err_early, o_err_nolast;
   logic [CNT_BIT-1:0] o_wr_cnt;
   logic [DWIDTH-1:0]  s_axis_tdata;
   logic               s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [AWIDTH-1:0]  addr_b0;
   logic               ce_b0, we_b0;
   logic [DWIDTH-1:0]  d_b0;

   axis_to_bram_writer #(
      .CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE)
   ) dut (
      .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
      .o_idle(o_idle), .o_run(o_run), .o_done(o_done),
      .o_err_early(o_err_early), .o_err_nolast(o_err_nolast), .o_wr_cnt(o_wr_cnt),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .d_b0(d_b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  we_cnt  = 0;
   int  done_cnt = 0;
   wr_t exp_q[$];
   logic [DWIDTH-1:0] mem [MEM_SIZE];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // BRAM model
   always @(posedge clk) begin
      if (ce_b0 && we_b0) mem[addr_b0] <= d_b0;
   end

   // Write monitor: every strobe must match the next queued expectation.
   always @(negedge clk) begin
      if (o_done) done_cnt++;
      if (ce_b0 && we_b0) begin
         we_cnt++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                     addr_b0, d_b0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(addr_b0), 64'(e.addr));
            check("wr_data", 64'(d_b0), 64'(e.data));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic push_writes(input int n, input logic [DWIDTH-1:0] base);
      for (int i = 0; i < n; i++) begin
         wr_t e;
         e.addr = AWIDTH'(i);
         e.data = base + DWIDTH'(i);
         exp_q.push_back(e);
      end
   endtask

   // Start pulse with tvalid optionally already high while still idle.
   task automatic start(input int num, input logic [DWIDTH-1:0] base, input bit valid);
      @(posedge clk); #1;
      we_cnt = 0;
      done_cnt = 0;
      i_run = 1'b1;
      i_num_cnt = CNT_BIT'(num);
      s_axis_tvalid = valid;
      s_axis_tdata = base;
      s_axis_tlast = 1'b0;
      @(negedge clk);
      check("idle_tready", 64'(s_axis_tready), 64'd0);
      check("idle_flag", 64'(o_idle), 64'd1);
      @(posedge clk); #1;
      i_run = 1'b0;
   endtask

   task automatic run_xfer(input int num, input int offered, input int last_idx,
                           input bit gated, input int abort_at, input int max_cyc,
                           input logic [DWIDTH-1:0] base,
                           output int acc, output int dcyc);
      int  extra, post;
      bit  dseen, gate;
      acc = 0; extra = 0; post = 0; dseen = 0; dcyc = 0;
      start(num, base, offered > 0);
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         if (cyc > 1) begin
            @(posedge clk); #1;
         end
         gate = gated ? ($urandom % 2 == 0) : 1'b1;
         s_axis_tvalid = (acc < offered) && gate;
         s_axis_tdata  = base + DWIDTH'(acc);
         s_axis_tlast  = (acc == last_idx);
         @(negedge clk);
         if (cyc == 1) check("start_wr_cnt", 64'(o_wr_cnt), 64'd0);
         if (s_axis_tvalid && s_axis_tready) begin
            if (dseen) extra++;
            acc++;
         end
         if (o_done && !dseen) begin
            dseen = 1'b1;
            dcyc = cyc;
         end else if (dseen) begin
            post++;
         end
         if (abort_at >= 0 && acc == abort_at) break;
         if (post >= 4) break;
      end
      if (abort_at < 0) begin
         check("done_seen", 64'(dseen), 64'd1);
         check("beats_after_done", 64'(extra), 64'd0);
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic check_mem(input string name, input int lo, input int hi,
                            input logic [DWIDTH-1:0] base);
      int bad = 0;
      for (int i = lo; i < hi; i++) begin
         if (mem[i] !== base + DWIDTH'(i - lo)) bad++;
      end
      check(name, 64'(bad), 64'd0);
   endtask

   int acc, dcyc;

   initial begin
      reset = 1'b1; i_run = 1'b0; i_num_cnt = '0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_idle",  64'(o_idle), 64'd1);
      check("rst_run",   64'(o_run), 64'd0);
      check("rst_done",  64'(o_done), 64'd0);
      check("rst_errs",  64'({o_err_early, o_err_nolast}), 64'd0);
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_ce_we", 64'({ce_b0, we_b0}), 64'd0);
      check("rst_wr_cnt", 64'(o_wr_cnt), 64'd0);
      check("rst_addr_d", 64'({addr_b0, d_b0}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: full continuous burst
      push_writes(3840, 32'd0);
      run_xfer(3840, 3840, 3839, 1'b0, -1, 4000, 32'd0, acc, dcyc);
      check("t1_accepted", 64'(acc), 64'd3840);
      check("t1_done_cycle", 64'(dcyc), 64'd3841);
      check("t1_done_cnt", 64'(done_cnt), 64'd1);
      check("t1_we_cnt", 64'(we_cnt), 64'd3840);
      check("t1_wr_cnt", 64'(o_wr_cnt), 64'd3840);
      check("t1_errs", 64'({o_err_early, o_err_nolast}), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      check_mem("t1_mem", 0, 3840, 32'd0);
      check("t1_mem_untouched", 64'(mem[3840]), 64'hDEAD_BEEF);

      // 2: same burst, tvalid gated at 50%
      for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 32'hDEAD_BEEF;
      push_writes(3840, 32'd0);
      run_xfer(3840, 3840, 3839, 1'b1, -1, 12000, 32'd0, acc, dcyc);
      check("t2_accepted", 64'(acc), 64'd3840);
      check("t2_done_cnt", 64'(done_cnt), 64'd1);
      check("t2_we_cnt", 64'(we_cnt), 64'd3840);
      check("t2_wr_cnt", 64'(o_wr_cnt), 64'd3840);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
      check_mem("t2_mem", 0, 3840, 32'd0);

      // 3: early tlast on beat 9 of 16
      push_writes(10, 32'hA000_0000);
      run_xfer(16, 16, 9, 1'b0, -1, 100, 32'hA000_0000, acc, dcyc);
      check("t3_accepted", 64'(acc), 64'd10);
      check("t3_wr_cnt", 64'(o_wr_cnt), 64'd10);
      check("t3_err_early", 64'(o_err_early), 64'd1);
      check("t3_err_nolast", 64'(o_err_nolast), 64'd0);
      check("t3_done_cnt", 64'(done_cnt), 64'd1);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // 4: count of 8 reached without tlast, 12 beats offered
      push_writes(8, 32'hB000_0000);
      run_xfer(8, 12, -1, 1'b0, -1, 100, 32'hB000_0000, acc, dcyc);
      check("t4_accepted", 64'(acc), 64'd8);
      check("t4_wr_cnt", 64'(o_wr_cnt), 64'd8);
      check("t4_err_nolast", 64'(o_err_nolast), 64'd1);
      check("t4_err_early", 64'(o_err_early), 64'd0);
      check("t4_we_cnt", 64'(we_cnt), 64'd8);
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

      // 5: zero-length transfer
      run_xfer(0, 0, -1, 1'b0, -1, 20, 32'd0, acc, dcyc);
      check("t5_done_cycle", 64'(dcyc), 64'd1);
      check("t5_done_cnt", 64'(done_cnt), 64'd1);
      check("t5_we_cnt", 64'(we_cnt), 64'd0);
      check("t5_wr_cnt", 64'(o_wr_cnt), 64'd0);
      check("t5_errs", 64'({o_err_early, o_err_nolast}), 64'd0);

      // 6: reset after 100 beats, then a fresh short run
      push_writes(100, 32'h1000_0000);
      run_xfer(3840, 3840, 3839, 1'b0, 100, 400, 32'h1000_0000, acc, dcyc);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t6_idle", 64'(o_idle), 64'd1);
      check("t6_tready", 64'(s_axis_tready), 64'd0);
      check("t6_we", 64'(we_b0), 64'd0);
      check("t6_accepted", 64'(acc), 64'd100);
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      check_mem("t6_mem_kept", 0, 100, 32'h1000_0000);
      check("t6_mem_beyond", 64'(mem[100]), 64'd100);
      push_writes(20, 32'h2000_0000);
      run_xfer(20, 20, 19, 1'b0, -1, 100, 32'h2000_0000, acc, dcyc);
      check("t6b_accepted", 64'(acc), 64'd20);
      check("t6b_wr_cnt", 64'(o_wr_cnt), 64'd20);
      check("t6b_errs", 64'({o_err_early, o_err_nolast}), 64'd0);
      check("t6b_done_cnt", 64'(done_cnt), 64'd1);
      check("t6b_queue_empty", 64'(exp_q.size()), 64'd0);
      check_mem("t6b_mem", 0, 20, 32'h2000_0000);
      check_mem("t6b_mem_kept", 20, 100, 32'h1000_0014);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
